pin_pattern_sequencer: RTL and testbench

Sequences the board pin-test pattern generators that drive the evaluation board's I/O bank. Holds one WIDTH-bit pattern register and a mode register, and advances the pattern once per prescaled tick. Modes change on a user step request or automatically after a fixed number of ticks. The output bus drives the test pins directly; mode and tick are exported for LEDs and debug.

---
 rtl/pin_pattern_sequencer_if.sv | 30 +++
 rtl/pin_pattern_sequencer.sv | 142 ++++++++++++++
 tb/tb_pin_pattern_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pin_pattern_sequencer_if.sv
// Pin-pattern sequencer bus: user controls in, pin pattern and status out.
// The master side drives the controls; the slave side is the sequencer.
interface pin_pattern_sequencer_if #(
   parameter int WIDTH = 110
);
   logic             step_req;
   logic             auto_en;
   logic             hold;
   logic [WIDTH-1:0] D;
   logic [2:0]       mode;
   logic             tick;

   modport master (
      output step_req,
      output auto_en,
      output hold,
      input  D,
      input  mode,
      input  tick
   );

   modport slave (
      input  step_req,
      input  auto_en,
      input  hold,
      output D,
      output mode,
      output tick
   );
endinterface

// File: rtl/pin_pattern_sequencer.sv
// Pin-test pattern sequencer: one WIDTH-bit pattern register advanced once per
// prescaled tick, with six pattern modes selected by a user step or automatically
// after EPOCH ticks. The pattern drives the I/O bank pins directly.
module pin_pattern_sequencer #(
   parameter int WIDTH     = 110,
   parameter int LOG2DELAY = 22,
   parameter int EPOCH     = 64
) (
   input logic                    pclk,
   input logic                    rst,
   pin_pattern_sequencer_if.slave bus
);

   localparam int EPOCH_W = (EPOCH > 1) ? $clog2(EPOCH) : 1;
   localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(EPOCH - 1);

   typedef enum logic [2:0] {
      MODE_OFF     = 3'd0,
      MODE_ALL_ON  = 3'd1,
      MODE_WALK    = 3'd2,
      MODE_CA      = 3'd3,
      MODE_GRAY    = 3'd4,
      MODE_CHECKER = 3'd5
   } mode_e;

   mode_e                mode_q;
   mode_e                mode_d;
   logic [WIDTH-1:0]     pattern_q;
   logic [WIDTH-1:0]     pattern_d;
   logic [WIDTH-1:0]     gray_q;
   logic [WIDTH-1:0]     gray_d;
   logic [LOG2DELAY-1:0] presc_q;
   logic [EPOCH_W-1:0]   epoch_q;
   logic                 step_prev_q;
   logic                 tick_q;

   logic step_edge;
   logic tick_event;
   logic auto_trig;
   logic mode_valid;
   logic advance;

   // Pattern loaded when a mode is entered.
   function automatic logic [WIDTH-1:0] seed_of(input mode_e m);
      logic [WIDTH-1:0] s;
      s = '0;
      case (m)
         MODE_ALL_ON:       s = '1;
         MODE_WALK,
         MODE_CA:           s = WIDTH'(1);
         MODE_CHECKER: begin
            for (int i = 0; i < WIDTH; i += 2) s[i] = 1'b1;
         end
         default:           s = '0;
      endcase
      return s;
   endfunction

   // One generation of the circular cellular automaton:
   // next[i] = r[i+1] ^ (r[i] | r[i-1]), indices wrapping around the bank.
   function automatic logic [WIDTH-1:0] ca_step(input logic [WIDTH-1:0] r);
      logic [WIDTH-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) begin
         n[i] = r[(i + 1) % WIDTH] ^ (r[i] | r[(i + WIDTH - 1) % WIDTH]);
      end
      return n;
   endfunction

   // Mode register (FSM state).
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge pclk) begin
      if (rst) mode_q <= MODE_OFF;
      else     mode_q <= mode_d;
   end

   // Event detection and next mode: a step edge, an auto trigger or an illegal code advances.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      step_edge  = bus.step_req && !step_prev_q;
      tick_event = !bus.hold && (presc_q == '1);
      auto_trig  = tick_event && bus.auto_en && (epoch_q == EPOCH_LAST);
      mode_valid = (mode_q <= MODE_CHECKER);
      advance    = step_edge || auto_trig || !mode_valid;
      mode_d     = mode_q;
      if (advance) begin
         mode_d = (mode_q >= MODE_CHECKER) ? MODE_OFF : mode_e'(mode_q + 3'd1);
      end
   end

   // Next pattern: seed of the new mode on advance, otherwise the per-tick update.
   always_comb begin
      pattern_d = pattern_q;
      gray_d    = gray_q;
      if (advance) begin
         pattern_d = seed_of(mode_d);
         gray_d    = '0;
      end else if (tick_event) begin
         case (mode_q)
            MODE_WALK:    pattern_d = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
            MODE_CA:      pattern_d = ca_step(pattern_q);
            MODE_GRAY: begin
               gray_d    = gray_q + WIDTH'(1);
               pattern_d = gray_d ^ (gray_d >> 1);
            end
            MODE_CHECKER: pattern_d = ~pattern_q;
            default:      pattern_d = pattern_q;
         endcase
      end
   end

   // Datapath registers: pattern, gray counter, prescaler, epoch count, step history, tick pulse.
   always_ff @(posedge pclk) begin
      if (rst) begin
         pattern_q   <= '0;
         gray_q      <= '0;
         presc_q     <= '0;
         epoch_q     <= '0;
         step_prev_q <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         pattern_q   <= pattern_d;
         gray_q      <= gray_d;
         step_prev_q <= bus.step_req;
         // An advance edge shows a seed, not a tick-updated pattern.
         tick_q      <= tick_event && !advance;
         if (advance) begin
            presc_q <= '0;
            epoch_q <= '0;
         end else begin
            // Wraps from all-ones to zero on the tick edge.
            if (!bus.hold) presc_q <= presc_q + LOG2DELAY'(1);
            if (tick_event && (epoch_q != EPOCH_LAST)) epoch_q <= epoch_q + EPOCH_W'(1);
         end
      end
   end

   assign bus.D    = pattern_q;
   assign bus.mode = mode_q;
   assign bus.tick = tick_q;

endmodule

// File: tb/tb_pin_pattern_sequencer.sv
// Directed bench for pin_pattern_sequencer (WIDTH=8, LOG2DELAY=3, EPOCH=4).
// Expected pin/mode/tick values are queued as stimulus is applied and popped
// and compared one cycle at a time, #1 after each rising edge.
module tb_pin_pattern_sequencer;

   localparam int WIDTH = 8;

   typedef struct {
      string      tag;
      logic [7:0] d;
      logic [2:0] mode;
      logic       tick;
   } exp_t;

   logic       pclk;
   logic       rst;
   exp_t       sb[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] cur_d;
   logic [2:0] cur_mode;
   int         phase;
   logic [7:0] b;

   pin_pattern_sequencer_if #(.WIDTH(WIDTH)) bus ();

   pin_pattern_sequencer #(
      .WIDTH    (WIDTH),
      .LOG2DELAY(3),
      .EPOCH    (4)
   ) dut (
      .pclk(pclk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no end of test, expected finish before 100000 ns");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [2:0] next_mode(input logic [2:0] m);
      return (m == 3'd5) ? 3'd0 : m + 3'd1;
   endfunction

   function automatic logic [7:0] ca8(input logic [7:0] r);
      logic [7:0] n;
      for (int i = 0; i < 8; i++) n[i] = r[(i + 1) % 8] ^ (r[i] | r[(i + 7) % 8]);
      return n;
   endfunction

   task automatic cyc();
      @(posedge pclk);
      #1;
   endtask

   task automatic expect_now(input string tag, input logic [7:0] d, input logic [2:0] m,
                             input logic t);
      exp_t e;
      e.tag  = tag;
      e.d    = d;
      e.mode = m;
      e.tick = t;
      sb.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      n_checks++;
      assert (sb.size() > 0) else begin
         n_fail++;
         $error("FAIL scoreboard: observed empty queue, expected an entry");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         assert (bus.D === e.d) else begin
            n_fail++;
            $error("FAIL %s D: observed %h expected %h", e.tag, bus.D, e.d);
         end
         n_checks++;
         assert (bus.mode === e.mode) else begin
            n_fail++;
            $error("FAIL %s mode: observed %0d expected %0d", e.tag, bus.mode, e.mode);
         end
         n_checks++;
         assert (bus.tick === e.tick) else begin
            n_fail++;
            $error("FAIL %s tick: observed %b expected %b", e.tag, bus.tick, e.tick);
         end
      end
   endtask

   // n edges with no tick expected; the phase only moves while hold is low.
   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         if (!bus.hold) phase++;
         expect_now(tag, cur_d, cur_mode, 1'b0);
         check_pop();
      end
   endtask

   // Quiet edges up to the next tick, then the tick edge with its new pattern.
   task automatic tick_to(input string tag, input logic [7:0] new_d);
      idle(tag, 7 - phase);
      cyc();
      cur_d = new_d;
      phase = 0;
      expect_now(tag, cur_d, cur_mode, 1'b1);
      check_pop();
   endtask

   // Quiet edges up to the next tick, which is expected to auto-advance the mode.
   task automatic auto_adv(input string tag, input logic [7:0] seed);
      idle(tag, 7 - phase);
      cyc();
      cur_mode = next_mode(cur_mode);
      cur_d    = seed;
      phase    = 0;
      expect_now(tag, cur_d, cur_mode, 1'b0);
      check_pop();
   endtask

   task automatic do_step(input string tag, input logic [7:0] seed, input bit keep_high);
      bus.step_req = 1'b1;
      cyc();
      if (!keep_high) bus.step_req = 1'b0;
      cur_mode = next_mode(cur_mode);
      cur_d    = seed;
      phase    = 0;
      expect_now(tag, cur_d, cur_mode, 1'b0);
      check_pop();
   endtask

   initial begin
      rst          = 1'b1;
      bus.step_req = 1'b0;
      bus.auto_en  = 1'b0;
      bus.hold     = 1'b0;
      cyc();
      cyc();
      rst      = 1'b0;
      cur_d    = 8'h00;
      cur_mode = 3'd0;
      phase    = 0;
      expect_now("reset", 8'h00, 3'd0, 1'b0);
      check_pop();

      // Mode OFF: ticks still pulse, pattern stays zero over 32 cycles.
      for (int i = 0; i < 4; i++) tick_to("off_static", 8'h00);

      // Two steps to WALK, then a full rotation.
      do_step("step_all_on", 8'hFF, 1'b0);
      idle("rearm", 1);
      do_step("step_walk", 8'h01, 1'b0);
      for (int i = 0; i < 8; i++) tick_to("walk", {cur_d[6:0], cur_d[7]});
      idle("walk_back_to_seed", 0);

      // CA from the single-bit seed.
      do_step("step_ca", 8'h01, 1'b0);
      tick_to("ca_t1", 8'h83);
      tick_to("ca_t2", ca8(8'h83));

      // GRAY sequence 00, 01, 03, 02, 06.
      do_step("step_gray", 8'h00, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         b = 8'(i);
         tick_to("gray", b ^ (b >> 1));
      end

      // Reset with a partial period pending.
      idle("gray_partial", 3);
      rst = 1'b1;
      cyc();
      rst      = 1'b0;
      cur_d    = 8'h00;
      cur_mode = 3'd0;
      phase    = 0;
      expect_now("mid_reset", 8'h00, 3'd0, 1'b0);
      check_pop();
      tick_to("first_tick_after_reset", 8'h00);

      // Walk through the modes to CHECKER; the last step is held high.
      do_step("to_all_on", 8'hFF, 1'b0);
      idle("rearm", 1);
      do_step("to_walk", 8'h01, 1'b0);
      idle("rearm", 1);
      do_step("to_ca", 8'h01, 1'b0);
      idle("rearm", 1);
      do_step("to_gray", 8'h00, 1'b0);
      idle("rearm", 1);
      do_step("to_checker", 8'h55, 1'b1);
      idle("step_held_high", 3);
      bus.step_req = 1'b0;

      // Automatic advance after EPOCH ticks.
      bus.auto_en = 1'b1;
      tick_to("checker_t1", 8'hAA);
      tick_to("checker_t2", 8'h55);
      tick_to("checker_t3", 8'hAA);
      auto_adv("auto_advance", 8'h00);
      bus.auto_en = 1'b0;

      // Hold mid-period freezes everything; the count resumes where it stopped.
      do_step("to_all_on_2", 8'hFF, 1'b0);
      idle("rearm", 1);
      do_step("to_walk_2", 8'h01, 1'b0);
      idle("pre_hold", 3);
      bus.hold = 1'b1;
      idle("hold", 20);
      bus.hold = 1'b0;
      tick_to("hold_resume", 8'h02);

      // Step edge honoured under hold.
      bus.hold = 1'b1;
      idle("hold_again", 2);
      do_step("step_under_hold", 8'h01, 1'b0);
      idle("hold_after_step", 1);
      bus.hold = 1'b0;
      tick_to("ca_after_hold", 8'h83);

      // Step edge on the same edge as a tick event: seed only, no tick.
      idle("pre_coincide", 7);
      do_step("step_on_tick", 8'h00, 1'b0);
      tick_to("gray_after_coincide", 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
